// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-clock frame, ack).
// Latency: CLK_INHIBIT + START_HOLD cycles before device clocking; each line bit is updated 1 cycle after the synchronized falling edge.
// Backpressure: tx_start is accepted only in IDLE outside the done cycle; requests while busy are dropped.
//
// Ports:
//   clk, reset              : system clock, asynchronous active-high reset
//   tx_start, tx_data[7:0]  : one-cycle send request and command byte
//   ps2_clk_in, ps2_data_in : sensed PS/2 lines (asynchronous to clk)
//   ps2_clk_oe, ps2_data_oe : open-drain pull-low enables for the PS/2 lines
//   busy, done, err         : transfer in progress, end-of-transfer pulse, failure flag (valid with done)

module ps2_host_tx #(
  parameter int CLK_INHIBIT = 10000,
  parameter int START_HOLD  = 200,
  parameter int TIMEOUT     = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PH_MAX = (CLK_INHIBIT > START_HOLD) ? CLK_INHIBIT : START_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              parity_q, parity_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ack_err_q, ack_err_d;
  logic              clk_meta_q, clk_meta_d;
  logic              clk_sync_q, clk_sync_d;
  logic              clk_prev_q, clk_prev_d;
  logic              dat_meta_q, dat_meta_d;
  logic              dat_sync_q, dat_sync_d;
  logic              fell;

  // Device clock edge as seen after the two-flop synchronizer.
  assign fell = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tmo_d       = tmo_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    parity_d    = parity_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    err_d       = err_q;
    ack_err_d   = ack_err_q;
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    dat_meta_d  = ps2_data_in;
    dat_sync_d  = dat_meta_q;

    case (state_q)
      IDLE: begin
        clk_oe_d    = 1'b0;
        data_oe_d   = 1'b0;
        phase_cnt_d = '0;
        tmo_d       = '0;
        bit_cnt_d   = '0;
        // done_q blocks acceptance so a finished transfer and a new start never share a cycle.
        if (tx_start && !done_q) begin
          byte_d   = tx_data;
          parity_d = ~^tx_data;
          err_d    = 1'b0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (phase_cnt_q == PH_W'(CLK_INHIBIT - 1)) begin
          phase_cnt_d = '0;
          data_oe_d   = 1'b1;          // start bit
          state_d     = REQ;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end

      REQ: begin
        if (phase_cnt_q == PH_W'(START_HOLD - 1)) begin
          phase_cnt_d = '0;
          clk_oe_d    = 1'b0;          // hand the clock to the device, start bit stays low
          bit_cnt_d   = '0;
          tmo_d       = '0;
          state_d     = BITS;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end

      BITS: begin
        if (fell) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;          // stop bit: release data
            state_d   = ACK;
          end
        end
      end

      ACK: begin
        if (fell) begin
          bit_cnt_d = 4'd11;
          ack_err_d = dat_sync_q;      // device pulls data low to acknowledge
          state_d   = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          err_d   = ack_err_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Device-paced states: abort if the device stops clocking for TIMEOUT cycles.
    if (state_q == BITS || state_q == ACK || state_q == WAIT_IDLE) begin
      if (fell) begin
        tmo_d = '0;
      end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
        tmo_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        err_d     = 1'b1;
        state_d   = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      tmo_q       <= '0;
      bit_cnt_q   <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_err_q   <= 1'b0;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      tmo_q       <= tmo_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ack_err_q   <= ack_err_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      dat_meta_q  <= dat_meta_d;
      dat_sync_q  <= dat_sync_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host over
// open-drain lines and the captured frames are compared with the expected framing.

module tb_ps2_host_tx;

  localparam int CLK_INHIBIT = 100;
  localparam int START_HOLD  = 20;
  localparam int TIMEOUT     = 1000;
  localparam int HALF        = 20;  // device clock half period in system cycles
  // Pin fall to host's timeout counter clear: two synchronizer flops plus the previous-sample flop.
  localparam int EDGE_LAT    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int inh_cnt = 0;
  int req_cnt = 0;

  // Open-drain wiring: either side can pull a line low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_INHIBIT(CLK_INHIBIT),
    .START_HOLD (START_HOLD),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cumulative observations; the main sequence takes differences around each transfer.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
    if (ps2_clk_oe && ps2_data_oe) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line values seen before falling edges 1..11: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device model: waits for the host's request-to-send, then produces n_edges
  // clock pulses, sampling the data line just before each falling edge.
  task automatic device(input int n_edges, input bit ack, input int reset_edge,
                        output logic [10:0] rx, output int last_fall);
    int  t;
    bit  stop;
    rx        = '1;
    last_fall = 0;
    stop      = 1'b0;
    t = 0;
    while (!ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
    check("host_grabs_clock", 32'(ps2_clk_oe), 32'd1);
    t = 0;
    while (ps2_clk_oe && t < 5000) begin @(negedge clk); t++; end
    check("host_releases_clock", 32'(ps2_clk_oe), 32'd0);
    for (int k = 1; k <= n_edges && !stop; k++) begin
      repeat (HALF) @(negedge clk);
      rx[k-1] = ps2_data_in;
      if (k == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk   = 1'b0;
      last_fall = cyc;
      if (k == reset_edge) begin
        repeat (4) @(negedge clk);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
        reset = 1'b1;
        stop  = 1'b1;
      end else begin
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
      end
    end
    if (!stop) dev_data = 1'b1;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_full(input logic [7:0] b, input bit ack);
    logic [10:0] rx;
    int lf, inh0, req0, dn0;
    bit seen;
    inh0 = inh_cnt; req0 = req_cnt; dn0 = done_cnt;
    start_tx(b);
    check("busy_after_start", 32'(busy), 32'd1);
    device(11, ack, 0, rx, lf);
    check("frame", 32'(rx), 32'(frame(b)));
    wait_done(300, seen);
    check("done_seen", 32'(seen), 32'd1);
    check("err", 32'(err), 32'(!ack));
    check("oe_at_done", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    repeat (3) @(negedge clk);
    check("inhibit_len", 32'(inh_cnt - inh0), 32'(CLK_INHIBIT));
    check("req_len", 32'(req_cnt - req0), 32'(START_HOLD));
    check("done_pulses", 32'(done_cnt - dn0), 32'd1);
  endtask

  initial begin
    logic [10:0] rx;
    int  lf, dn0;
    bit  seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED acknowledged
    run_full(8'hED, 1'b1);

    // 0x01 not acknowledged: parity bit 0, err
    run_full(8'h01, 1'b0);

    // 0xF4 with device going silent after 5 edges
    start_tx(8'hF4);
    device(5, 1'b1, 0, rx, lf);
    check("timeout_partial_frame", 32'(rx[4:0]), 32'(5'b01000));
    wait_done(TIMEOUT + 200, seen);
    check("timeout_done_seen", 32'(seen), 32'd1);
    check("timeout_latency", 32'(cyc - lf), 32'(TIMEOUT + EDGE_LAT));
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    repeat (3) @(negedge clk);

    // 0x00 with a 0xFF request arriving during REQ
    dn0 = done_cnt;
    start_tx(8'h00);
    fork
      device(11, 1'b1, 0, rx, lf);
      begin
        int t = 0;
        while (!(ps2_clk_oe && ps2_data_oe) && t < 2000) begin @(negedge clk); t++; end
        check("inject_in_req", 32'(ps2_data_oe), 32'd1);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check("ignored_req_frame", 32'(rx), 32'(frame(8'h00)));
    wait_done(300, seen);
    check("ignored_req_done", 32'(seen), 32'd1);
    check("ignored_req_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    check("ignored_req_single_done", 32'(done_cnt - dn0), 32'd1);

    // Reset at falling edge 4
    dn0 = done_cnt;
    start_tx(8'h00);
    device(11, 1'b1, 4, rx, lf);
    #1;
    check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dn0), 32'd0);
    run_full(8'hED, 1'b1);

    // Back-to-back: request in the done cycle is dropped, the next cycle's is taken
    start_tx(8'hC3);
    device(11, 1'b1, 0, rx, lf);
    check("b2b_first_frame", 32'(rx), 32'(frame(8'hC3)));
    wait_done(300, seen);
    check("b2b_first_done", 32'(seen), 32'd1);
    tx_data  = 8'h33;
    tx_start = 1'b1;
    @(negedge clk);
    check("done_cycle_req_ignored", 32'(ps2_clk_oe), 32'd0);
    check("done_cycle_busy", 32'(busy), 32'd0);
    tx_data = 8'h5A;
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b_inhibit_starts", 32'(ps2_clk_oe), 32'd1);
    device(11, 1'b1, 0, rx, lf);
    check("b2b_second_frame", 32'(rx), 32'(frame(8'h5A)));
    wait_done(300, seen);
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_second_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);

    // Random bytes and acknowledge behaviour
    for (int i = 0; i < 4; i++) begin
      run_full(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
